// File: rtl/design124_sig_pkg.sv
// Shared types and helpers for the design124 signature collector.
// The MISR step function is written for any width up to 64 bits.
package design124_sig_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_COLLECT = 2'd2,
    S_HOLD    = 2'd3
  } sig_state_t;

  localparam logic [31:0] SIG_POLY_DEFAULT = 32'h04C1_1DB7;

  // One MISR step on the low `width` bits: shift left, fold the dropped MSB
  // back through the taps, then absorb the new sample.
  function automatic logic [63:0] misr_next(input logic [63:0] misr,
                                            input logic [63:0] din,
                                            input logic [63:0] poly,
                                            input int unsigned width);
    logic [63:0] mask;
    logic        msb;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    msb  = |(misr & (64'd1 << (width - 1)));
    return (((misr << 1) ^ (msb ? poly : 64'd0)) ^ din) & mask;
  endfunction

endpackage

// File: rtl/design124_misr.sv
// WIDTH-bit multiple-input signature register with synchronous clear and enable.
// With SIG_CHECK_EN the next-state value is exported for the signature compare.
module design124_misr
  import design124_sig_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(SIG_POLY_DEFAULT)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
`ifdef SIG_CHECK_EN
  output logic [WIDTH-1:0] misr_nxt_o,
`endif
  output logic [WIDTH-1:0] misr_o
);

  logic [WIDTH-1:0] misr_q, misr_d, step;

  assign step = WIDTH'(misr_next(64'(misr_q), 64'(din_i), 64'(POLY), WIDTH));

  always_comb begin
    misr_d = misr_q;
    if (clr_i) begin
      misr_d = '0;
    end else if (en_i) begin
      misr_d = step;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      misr_q <= '0;
    end else begin
      misr_q <= misr_d;
    end
  end

  assign misr_o = misr_q;
`ifdef SIG_CHECK_EN
  assign misr_nxt_o = step;
`endif

endmodule

// File: rtl/design124_sig_collector.sv
// Signature collector: skip SETTLE cycles, compact WINDOW samples, offer result.
// Optional golden compare (exp_sig/pass) is built only with SIG_CHECK_EN.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_SETTLE  | pipeline fill, din ignored
// S_COLLECT | one MISR update per cycle
// S_HOLD    | signature offered until sig_ready
module design124_sig_collector
  import design124_sig_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter int unsigned      SETTLE = 20,
  parameter int unsigned      WINDOW = 64,
  parameter logic [WIDTH-1:0] POLY   = WIDTH'(SIG_POLY_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              din,
  input  logic                          sig_ready,
`ifdef SIG_CHECK_EN
  input  logic [WIDTH-1:0]              exp_sig,
  output logic                          pass,
`endif
  output logic [WIDTH-1:0]              sig,
  output logic                          sig_valid,
  output logic                          busy,
  output logic [$clog2(WINDOW+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(WINDOW + 1);
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  sig_state_t       state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CW-1:0]    count_q, count_d;
  logic             misr_clr, misr_en;
  logic [WIDTH-1:0] misr_val;
  logic             last_sample;

  assign last_sample = (state_q == S_COLLECT) && (count_q == CW'(WINDOW - 1));

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    count_d  = count_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          misr_clr = 1'b1;
          count_d  = '0;
          if (SETTLE > 0) begin
            state_d  = S_SETTLE;
            settle_d = SW'(SETTLE - 1);
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_COLLECT;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      S_COLLECT: begin
        misr_en = 1'b1;
        if (count_q != CW'(WINDOW)) begin
          count_d = count_q + 1'b1;
        end
        if (last_sample) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (sig_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      count_q  <= count_d;
    end
  end

`ifdef SIG_CHECK_EN
  logic [WIDTH-1:0] misr_nxt;
  logic             pass_q;

  // Compare against the value the MISR takes on the edge that enters HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_q <= 1'b0;
    end else if ((state_q == S_IDLE) && start) begin
      pass_q <= 1'b0;
    end else if (last_sample) begin
      pass_q <= (misr_nxt == exp_sig);
    end
  end

  assign pass = pass_q;
`endif

  design124_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clr_i      (misr_clr),
    .en_i       (misr_en),
    .din_i      (din),
`ifdef SIG_CHECK_EN
    .misr_nxt_o (misr_nxt),
`endif
    .misr_o     (misr_val)
  );

  assign sig       = misr_val;
  assign sig_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign count     = count_q;

endmodule

// File: tb/tb_design124_sig_collector.sv
// Randomized self-checking bench for design124_sig_collector (two parameterizations).
// Golden signatures come from a sample-list fold of the MISR rule; SIG_CHECK_EN adds pass checks.
module tb_design124_sig_collector;
  import design124_sig_pkg::*;

  localparam int unsigned AW = 3;
  localparam int unsigned BS = 20;
  localparam int unsigned BW = 8;
  localparam logic [31:0] P  = 32'h04C1_1DB7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_start = 0, a_ready = 0;
  logic [31:0] a_din = 0, a_exp = 0, a_sig;
  logic        a_valid, a_busy, a_pass;
  logic [1:0]  a_count;

  logic        b_start = 0, b_ready = 0;
  logic [31:0] b_din = 0, b_exp = 0, b_sig;
  logic        b_valid, b_busy, b_pass;
  logic [3:0]  b_count;

  int checks = 0;
  int failures = 0;
  logic [31:0] b_data [0:BS+BW];

  design124_sig_collector #(.WIDTH(32), .SETTLE(0), .WINDOW(AW), .POLY(P)) u_dut_a (
    .clk(clk), .rst(rst_n), .start(a_start), .din(a_din), .sig_ready(a_ready),
`ifdef SIG_CHECK_EN
    .exp_sig(a_exp), .pass(a_pass),
`endif
    .sig(a_sig), .sig_valid(a_valid), .busy(a_busy), .count(a_count)
  );

  design124_sig_collector #(.WIDTH(32), .SETTLE(BS), .WINDOW(BW), .POLY(P)) u_dut_b (
    .clk(clk), .rst(rst_n), .start(b_start), .din(b_din), .sig_ready(b_ready),
`ifdef SIG_CHECK_EN
    .exp_sig(b_exp), .pass(b_pass),
`endif
    .sig(b_sig), .sig_valid(b_valid), .busy(b_busy), .count(b_count)
  );

`ifndef SIG_CHECK_EN
  assign a_pass = 1'b0;
  assign b_pass = 1'b0;
`endif

  // Signature of a list of samples: multiply by x modulo the tap polynomial, add sample.
  function automatic logic [31:0] ref_sig(input logic [31:0] samples[$]);
    logic [31:0] acc;
    acc = 32'h0;
    foreach (samples[i]) begin
      if (acc[31]) acc = (acc << 1) ^ P;
      else         acc = acc << 1;
      acc = acc ^ samples[i];
    end
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_b();
    for (int k = 0; k <= BS + BW; k++) b_data[k] = $urandom;
  endtask

  task automatic run_b(output logic [31:0] exp);
    logic [31:0] q[$];
    for (int k = BS + 1; k <= BS + BW; k++) q.push_back(b_data[k]);
    exp = ref_sig(q);
    b_start = 1'b1;
    b_din = b_data[0];
    tick();
    b_start = 1'b0;
    for (int k = 1; k <= BS + BW; k++) begin
      b_din = b_data[k];
      tick();
      if (k == BS + BW - 1) begin
        checks++;
        if (b_valid !== 1'b0) begin
          failures++;
          $display("FAIL b_early_valid got=%b exp=0", b_valid);
        end
      end
    end
    checks++;
    if (b_valid !== 1'b1 || b_sig !== exp || b_count !== 4'(BW) || b_busy !== 1'b1) begin
      failures++;
      $display("FAIL b_final got valid=%b sig=%h count=%0d busy=%b exp valid=1 sig=%h count=%0d busy=1",
               b_valid, b_sig, b_count, b_busy, exp, BW);
    end
  endtask

  task automatic handshake_b();
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    checks++;
    if (b_valid !== 1'b0 || b_busy !== 1'b0) begin
      failures++;
      $display("FAIL b_handshake got valid=%b busy=%b exp valid=0 busy=0", b_valid, b_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (a_sig !== 32'h0 || a_valid !== 1'b0 || a_busy !== 1'b0 || a_count !== 2'd0 || a_pass !== 1'b0) begin
      failures++;
      $display("FAIL reset_a got sig=%h valid=%b busy=%b count=%0d pass=%b exp all 0",
               a_sig, a_valid, a_busy, a_count, a_pass);
    end
    checks++;
    if (b_sig !== 32'h0 || b_valid !== 1'b0 || b_busy !== 1'b0 || b_count !== 4'd0 || b_pass !== 1'b0) begin
      failures++;
      $display("FAIL reset_b got sig=%h valid=%b busy=%b count=%0d pass=%b exp all 0",
               b_sig, b_valid, b_busy, b_count, b_pass);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_a();
    a_din = 32'h1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++;
    if (a_busy !== 1'b1) begin
      failures++;
      $display("FAIL a_busy_after_start got=%b exp=1", a_busy);
    end
    tick();
    tick();
    checks++;
    if (a_valid !== 1'b0) begin
      failures++;
      $display("FAIL a_early_valid got=%b exp=0", a_valid);
    end
    tick();
    checks++;
    if (a_sig !== 32'h7 || a_valid !== 1'b1 || a_count !== 2'd3) begin
      failures++;
      $display("FAIL a_basic got sig=%h valid=%b count=%0d exp sig=00000007 valid=1 count=3",
               a_sig, a_valid, a_count);
    end
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    checks++;
    if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL a_handshake got valid=%b busy=%b exp 0 0", a_valid, a_busy);
    end
  endtask

  task automatic test_feedback();
    logic [63:0] nxt;
    logic [31:0] q[$];
    nxt = misr_next(64'h8000_0000, 64'h0, 64'(P), 32);
    checks++;
    if (nxt !== 64'h0000_0000_04C1_1DB7) begin
      failures++;
      $display("FAIL pkg_feedback got=%h exp=0000000004c11db7", nxt);
    end
    q = '{32'h8000_0000, 32'h0, 32'h0};
    a_start = 1'b1;
    a_din = $urandom;
    tick();
    a_start = 1'b0;
    a_din = 32'h8000_0000;
    tick();
    a_din = 32'h0;
    tick();
    checks++;
    if (a_sig !== 32'h04C1_1DB7) begin
      failures++;
      $display("FAIL dut_feedback got=%h exp=04c11db7", a_sig);
    end
    tick();
    checks++;
    if (a_sig !== ref_sig(q) || a_sig !== 32'h0982_3B6E) begin
      failures++;
      $display("FAIL dut_feedback_shift got=%h exp=%h", a_sig, ref_sig(q));
    end
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
  endtask

  task automatic test_settle_ignore();
    logic [31:0] e;
    fill_b();
    for (int k = BS + 1; k <= BS + BW; k++) b_data[k] = 32'h1;
    run_b(e);
    handshake_b();
    for (int k = 0; k <= BS; k++) b_data[k] = ~b_data[k] ^ $urandom;
    run_b(e);
    handshake_b();
  endtask

  task automatic test_random();
    logic [31:0] e;
    int unsigned d;
    for (int r = 0; r < 4; r++) begin
      fill_b();
      run_b(e);
      d = $urandom_range(0, 3);
      for (int i = 0; i < int'(d); i++) begin
        tick();
        checks++;
        if (b_valid !== 1'b1 || b_sig !== e) begin
          failures++;
          $display("FAIL rand_wait got valid=%b sig=%h exp valid=1 sig=%h", b_valid, b_sig, e);
        end
      end
      handshake_b();
    end
  endtask

  task automatic test_hold_stall();
    logic [31:0] e;
    fill_b();
    run_b(e);
    for (int i = 0; i < 10; i++) begin
      b_start = i[0];
      tick();
      checks++;
      if (b_valid !== 1'b1 || b_sig !== e || b_busy !== 1'b1 || b_count !== 4'(BW)) begin
        failures++;
        $display("FAIL hold_stall cyc=%0d got valid=%b sig=%h busy=%b count=%0d exp valid=1 sig=%h busy=1",
                 i, b_valid, b_sig, b_busy, b_count, e);
      end
    end
    b_start = 1'b0;
    handshake_b();
    tick();
    checks++;
    if (b_busy !== 1'b0 || b_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_no_restart got busy=%b valid=%b exp 0 0", b_busy, b_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    fill_b();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int k = 1; k <= BS + 5; k++) begin
      b_din = b_data[k];
      tick();
    end
    checks++;
    if (b_count !== 4'd5 || b_busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_count got count=%0d busy=%b exp count=5 busy=1", b_count, b_busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b_sig !== 32'h0 || b_valid !== 1'b0 || b_busy !== 1'b0 || b_count !== 4'd0 || b_pass !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got sig=%h valid=%b busy=%b count=%0d exp all 0",
               b_sig, b_valid, b_busy, b_count);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (b_busy !== 1'b0 || b_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got busy=%b valid=%b exp 0 0", b_busy, b_valid);
    end
    run_b(e);
    handshake_b();
  endtask

  task automatic test_back_to_back();
    a_din = 32'h1;
    a_start = 1'b1;
    a_ready = 1'b1;
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (a_valid !== 1'b1 || a_sig !== 32'h7) begin
      failures++;
      $display("FAIL b2b_first got valid=%b sig=%h exp valid=1 sig=00000007", a_valid, a_sig);
    end
    tick();
    checks++;
    if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got valid=%b busy=%b exp 0 0", a_valid, a_busy);
    end
    tick();
    checks++;
    if (a_busy !== 1'b1 || a_count !== 2'd0) begin
      failures++;
      $display("FAIL b2b_restart got busy=%b count=%0d exp busy=1 count=0", a_busy, a_count);
    end
    a_start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (a_valid !== 1'b1 || a_sig !== 32'h7 || a_count !== 2'd3) begin
      failures++;
      $display("FAIL b2b_second got valid=%b sig=%h count=%0d exp valid=1 sig=00000007 count=3",
               a_valid, a_sig, a_count);
    end
    tick();
    a_ready = 1'b0;
    checks++;
    if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got valid=%b busy=%b exp 0 0", a_valid, a_busy);
    end
  endtask

`ifdef SIG_CHECK_EN
  task automatic test_pass();
    for (int r = 0; r < 2; r++) begin
      a_din = 32'h1;
      a_exp = (r == 0) ? 32'h7 : 32'h6;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if (a_pass !== (r == 0)) begin
        failures++;
        $display("FAIL pass_run%0d got=%b exp=%b", r, a_pass, (r == 0));
      end
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      checks++;
      if (a_pass !== (r == 0)) begin
        failures++;
        $display("FAIL pass_held%0d got=%b exp=%b", r, a_pass, (r == 0));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_a();
    test_feedback();
    test_settle_ignore();
    test_random();
    test_hold_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef SIG_CHECK_EN
    test_pass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
